adc_frame_reader: RTL and testbench
===================================

# adc_frame_reader

Single-clock consumer for the ADC data path's system-side output. It pulls packed 32-bit sample words (channel B in bits 31:16, channel A in bits 15:0, each 14-bit sign-extended) through the valid/read-enable handshake. On a software arm, and optionally a level trigger, it captures a programmable number of words. It emits them as one AXI-Stream frame with `tlast`, for a DMA or packetizer in the `clk_sys_i` domain.

## Interface
Parameters:
- `FrameLenW`, default 16: width of the frame-length counter; maximum frame is 2^FrameLenW-1 words.

Ports:
- `clk_sys_i`, in, 1: system clock; all logic on the rising edge.
- `aresetn_i`, in, 1: reset, asynchronous assert, active-low.
- `adc_valid_i`, in, 1: upstream word available.
- `adc_data_i`, in, 32: upstream word, `{chB[15:0], chA[15:0]}`.
- `adc_rd_en_o`, out, 1: read enable to upstream; a transfer occurs when `adc_valid_i & adc_rd_en_o`.
- `arm_i`, in, 1: single-cycle pulse that starts a capture.
- `abort_i`, in, 1: single-cycle pulse that terminates a capture.
- `frame_len_i`, in, FrameLenW: words per frame, sampled on `arm_i`.
- `trig_level_i`, in, 16: signed channel-A threshold (used only with `ADC_FRAME_TRIG_EN`).
- `m_axis_tdata_o`, out, 32: output word.
- `m_axis_tvalid_o`, out, 1: output valid.
- `m_axis_tready_i`, in, 1: downstream ready.
- `m_axis_tlast_o`, out, 1: last word of frame.
- `busy_o`, out, 1: high in any state other than IDLE.
- `done_o`, out, 1: one-cycle pulse when the last beat is accepted.
- `truncated_o`, out, 1: sticky flag, set when a frame ended by abort; cleared by the next accepted arm.

## Operation
- Reset values: all outputs 0; state IDLE; counters 0.
- IDLE:
  - `adc_rd_en_o`=0 (upstream is back-pressured).
  - `arm_i` with `frame_len_i`≠0 latches the length, clears `truncated_o`, and moves to ARMED.
  - `arm_i` with `frame_len_i`=0 is ignored.
- ARMED:
  - `adc_rd_en_o`=1; pre-trigger words are consumed and discarded.
  - The trigger word is the first transferred word that meets the trigger condition. It is the first word of the frame; the state moves to CAPTURE.
- CAPTURE:
  - `adc_rd_en_o` = `~m_axis_tvalid_o | m_axis_tready_i`. There is a single output register, so full throughput is one word per clock.
  - Each transfer loads the output register and increments the word count.
  - `m_axis_tlast_o` is set with the word whose count equals the latched length.
  - After that word, `adc_rd_en_o` drops to 0 and the state moves to DRAIN.
- DRAIN:
  - `adc_rd_en_o`=0.
  - When the tlast beat is accepted, `done_o` pulses and the state returns to IDLE.
- AXI-Stream rules:
  - Once `m_axis_tvalid_o` is asserted, data and last hold until `m_axis_tready_i`.
  - Valid never drops without acceptance.
- `abort_i`:
  - In ARMED: go to IDLE.
  - In CAPTURE or DRAIN: if a beat is pending, force its `tlast` to 1 and go to DRAIN; otherwise go to IDLE.
  - In both cases, if at least one word was emitted, set `truncated_o`. If nothing was emitted, no frame is output.
  - `abort_i` has priority over a same-cycle transfer; that word is not read (`adc_rd_en_o` is gated low).
- `arm_i` outside IDLE is ignored.
- `abort_i` and `arm_i` in the same cycle in IDLE: the arm wins.
- Mid-operation reset returns everything to the reset values immediately, including dropping `tvalid`.

## Timing
- Read-to-output latency: 1 clock. A word transferred at edge n appears on `m_axis_tdata_o` after edge n.
- `arm_i` at edge n: `busy_o`=1 and `adc_rd_en_o`=1 after edge n.
- Trigger evaluation is combinational on the transferred word; there is no trigger-to-capture latency.
- `done_o` is asserted for the cycle after the edge at which the tlast beat is accepted.

## Configuration
- `ADC_FRAME_TRIG_EN` defined:
  - The trigger condition is a rising crossing on signed channel A: `prev_A < trig_level_i` and `cur_A ≥ trig_level_i`.
  - `prev_A` is the previous transferred word in ARMED, initialised to 16'h8000 on arm.
- `ADC_FRAME_TRIG_EN` not defined:
  - The trigger condition is always true; the first word transferred after arm starts the frame.
  - `trig_level_i` is unused, and no comparator or `prev_A` register is built.

## Test plan
- Basic frame (trigger disabled): arm with length 4, upstream words 0x0001_0001 through 0x0004_0004 continuously valid, tready=1 -> four beats back-to-back, tlast on 0x0004_0004, `done_o` one cycle later, `adc_rd_en_o`=0 afterward.
- Backpressure: length 8, tready toggling 1-0-1-0 -> output data stable while tready=0, upstream read only when the register frees, all 8 words in order, no duplicates or drops.
- Trigger (with `ADC_FRAME_TRIG_EN`): level 0x0100, chA sequence 0x0000, 0x0050, 0x0120, 0x0200, length 2 -> frame is chA 0x0120, 0x0200; earlier words discarded.
- Abort: length 10, abort after 3 beats accepted with a 4th pending -> 4th beat carries tlast, `truncated_o`=1, return to IDLE, no `done_o`.
- Zero length and re-arm while busy: arm with length 0 -> `busy_o` stays 0; arm with length 5, then arm with length 2 mid-frame -> 5-beat frame delivered.
- Reset mid-frame: deassert `aresetn_i` during CAPTURE with tvalid=1 -> all outputs 0 asynchronously; after release, a new arm produces a correct frame.

Source files
------------

// File: rtl/adc_frame_reader.sv
// adc_frame_reader: captures a frame of packed ADC words after an arm
// pulse and an optional level trigger, and sends it out as one AXI-Stream frame.
//
// Ports:
//   clk_sys_i / aresetn_i : clock and async active-low reset
//   adc_valid_i / adc_data_i / adc_rd_en_o : upstream word source
//   arm_i / abort_i / frame_len_i / trig_level_i : capture control
//   m_axis_t{data,valid,ready,last} : frame output
//   busy_o / done_o / truncated_o   : status
//
// Build option: define ADC_FRAME_TRIG_EN to add the rising-crossing
// trigger on channel A. Without it, the first word read after arm
// starts the frame.
module adc_frame_reader #(
  parameter int FrameLenW = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 aresetn_i,
  input  logic                 adc_valid_i,
  input  logic [31:0]          adc_data_i,
  output logic                 adc_rd_en_o,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic [FrameLenW-1:0] frame_len_i,
  input  logic [15:0]          trig_level_i,
  output logic [31:0]          m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  input  logic                 m_axis_tready_i,
  output logic                 m_axis_tlast_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 truncated_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [FrameLenW-1:0] len_q, len_d;
  logic [FrameLenW-1:0] cnt_q, cnt_d;
  logic [FrameLenW-1:0] cnt_inc;
  logic [31:0]          tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic                 done_q, done_d;
  logic                 trunc_q, trunc_d;

  logic rd_en;
  logic xfer;
  logic accept;
  logic pending;
  logic last_word;
  logic trig_hit;

  assign accept  = tvalid_q & m_axis_tready_i;
  assign pending = tvalid_q & ~m_axis_tready_i;

  // Abort gates the read so the word on the bus stays upstream.
  assign rd_en = ~abort_i &
                 ((state_q == ST_ARMED) |
                  ((state_q == ST_CAPTURE) &
                   (~tvalid_q | m_axis_tready_i)));

  assign xfer      = adc_valid_i & rd_en;
  assign cnt_inc   = cnt_q + FrameLenW'(1);
  assign last_word = (cnt_inc == len_q);

`ifdef ADC_FRAME_TRIG_EN
  logic [15:0] prev_a_q, prev_a_d;

  assign trig_hit =
    ($signed(prev_a_q) < $signed(trig_level_i)) &&
    ($signed(adc_data_i[15:0]) >= $signed(trig_level_i));

  // Start at the most negative code so the first word can cross.
  always_comb begin
    prev_a_d = prev_a_q;
    if ((state_q == ST_IDLE) && arm_i) begin
      prev_a_d = 16'h8000;
    end else if ((state_q == ST_ARMED) && xfer) begin
      prev_a_d = adc_data_i[15:0];
    end
  end

  always_ff @(posedge clk_sys_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      prev_a_q <= '0;
    end else begin
      prev_a_q <= prev_a_d;
    end
  end
`else
  logic unused_trig_level;
  assign unused_trig_level = ^trig_level_i;
  assign trig_hit          = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;
    trunc_d  = trunc_q;

    if (accept) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (arm_i && (frame_len_i != '0)) begin
          len_d   = frame_len_i;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (xfer && trig_hit) begin
          tdata_d  = adc_data_i;
          tvalid_d = 1'b1;
          tlast_d  = last_word;
          cnt_d    = cnt_inc;
          state_d  = last_word ? ST_DRAIN : ST_CAPTURE;
        end
      end
      ST_CAPTURE, ST_DRAIN: begin
        if (abort_i) begin
          trunc_d = (cnt_q != '0);
          if (pending) begin
            // The held beat closes the shortened frame.
            tlast_d = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state_q == ST_CAPTURE) begin
          if (xfer) begin
            tdata_d  = adc_data_i;
            tvalid_d = 1'b1;
            tlast_d  = last_word;
            cnt_d    = cnt_inc;
            state_d  = last_word ? ST_DRAIN : ST_CAPTURE;
          end
        end else if (accept) begin
          // An aborted frame ends without a done pulse.
          done_d  = ~trunc_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
      trunc_q  <= trunc_d;
    end
  end

  assign adc_rd_en_o     = rd_en;
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign truncated_o     = trunc_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// tb_adc_frame_reader: self-checking bench for adc_frame_reader.
// Frames are checked against a queue model of consumed upstream words.
module tb_adc_frame_reader;

  logic        clk_sys_i = 1'b0;
  logic        aresetn_i;
  logic        adc_valid_i;
  logic [31:0] adc_data_i;
  logic        adc_rd_en_o;
  logic        arm_i;
  logic        abort_i;
  logic [15:0] frame_len_i;
  logic [15:0] trig_level_i;
  logic [31:0] m_axis_tdata_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i;
  logic        m_axis_tlast_o;
  logic        busy_o;
  logic        done_o;
  logic        truncated_o;

  always #5 clk_sys_i = ~clk_sys_i;

  adc_frame_reader dut (
    .clk_sys_i       (clk_sys_i),
    .aresetn_i       (aresetn_i),
    .adc_valid_i     (adc_valid_i),
    .adc_data_i      (adc_data_i),
    .adc_rd_en_o     (adc_rd_en_o),
    .arm_i           (arm_i),
    .abort_i         (abort_i),
    .frame_len_i     (frame_len_i),
    .trig_level_i    (trig_level_i),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tready_i (m_axis_tready_i),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .truncated_o     (truncated_o)
  );

  typedef struct {
    int    len;
    int    vpct;
    int    rmode;
    int    rearm;
    int    src;
    logic  exp_busy;
    string name;
  } vec_t;

  logic [31:0] src_q[$];
  logic [31:0] consumed[$];
  logic [31:0] beats[$];
  logic        lasts[$];
  int          acc_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, done_bad, hold_bad;
  int v_pct, r_mode;
  logic        hold_pend, hold_last, ab_seen, ab_prev;
  logic [31:0] hold_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_inputs();
    adc_valid_i = (src_q.size() > 0) && ($urandom_range(0, 99) < v_pct);
    adc_data_i  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    if (r_mode == 200) m_axis_tready_i = ~m_axis_tready_i;
    else m_axis_tready_i = ($urandom_range(0, 99) < r_mode);
  endtask

  task automatic clear_bk();
    consumed.delete();
    beats.delete();
    lasts.delete();
    acc_cyc.delete();
    done_cnt = 0;
    done_bad = 0;
    hold_bad = 0;
    hold_pend = 0;
    ab_seen = 0;
    ab_prev = 0;
  endtask

  // One clock: observe handshakes before the edge, status after it.
  task automatic tick();
    logic xf, ac, exp_done;
    #1;
    if (hold_pend) begin
      if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== hold_data ||
          (!ab_prev && m_axis_tlast_o !== hold_last))
        hold_bad++;
    end
    hold_pend = m_axis_tvalid_o & ~m_axis_tready_i;
    hold_data = m_axis_tdata_o;
    hold_last = m_axis_tlast_o;
    xf = adc_valid_i & adc_rd_en_o;
    ac = m_axis_tvalid_o & m_axis_tready_i;
    if (xf) consumed.push_back(adc_data_i);
    if (ac) begin
      beats.push_back(m_axis_tdata_o);
      lasts.push_back(m_axis_tlast_o);
      acc_cyc.push_back(cyc);
    end
    if (abort_i) ab_seen = 1;
    ab_prev = abort_i;
    exp_done = ac & m_axis_tlast_o & ~ab_seen;
    @(posedge clk_sys_i);
    @(negedge clk_sys_i);
    cyc++;
    if (xf) void'(src_q.pop_front());
    if (done_o !== exp_done) done_bad++;
    if (done_o === 1'b1) done_cnt++;
    arm_i = 0;
    abort_i = 0;
    drive_inputs();
  endtask

  // Index of the trigger word within the consumed stream.
  function automatic int trig_start();
`ifdef ADC_FRAME_TRIG_EN
    int prev, cur, lvl;
    prev = -32768;
    lvl  = int'($signed(trig_level_i));
    for (int i = 0; i < consumed.size(); i++) begin
      cur = int'($signed(consumed[i][15:0]));
      if (prev < lvl && cur >= lvl) return i;
      prev = cur;
    end
    return -1;
`else
    return 0;
`endif
  endfunction

  task automatic run_frame(input int len, input int vpct,
                           input int rmode, input int rearm,
                           input int src, input logic exp_busy,
                           input string tag);
    int n, s, ecn;
    clear_bk();
    if (src == 0) begin
      src_q.delete();
      repeat (len + 200) src_q.push_back($urandom);
    end else if (src == 1) begin
      src_q.delete();
      for (int k = 1; k <= len + 8; k++)
        src_q.push_back({16'(k), 16'(k)});
    end
    v_pct = vpct;
    r_mode = rmode;
    if (rmode == 200) m_axis_tready_i = 1'b0;
    drive_inputs();
    frame_len_i = 16'(len);
    arm_i = 1;
    tick();
    chk({tag, ":busy_arm"}, 32'(busy_o), 32'(exp_busy));
    n = 0;
    while (busy_o === 1'b1 && n < 4000) begin
      if (n == rearm) begin
        arm_i = 1;
        frame_len_i = 16'd2;
      end
      tick();
      n++;
    end
    chk({tag, ":finish"}, 32'(busy_o), 32'h0);
    if (busy_o !== 1'b0) begin
      abort_i = 1;
      tick();
      tick();
    end
    s = trig_start();
    chk({tag, ":trig_found"}, 32'(s >= 0 || len == 0), 32'h1);
    if (s < 0) s = 0;
    ecn = (len == 0) ? 0 : s + len;
    chk({tag, ":beats"}, 32'(beats.size()), 32'(len));
    chk({tag, ":consumed"}, 32'(consumed.size()), 32'(ecn));
    for (int i = 0; i < beats.size() && i < len; i++) begin
      if (s + i < consumed.size())
        chk({tag, ":data"}, beats[i], consumed[s + i]);
      chk({tag, ":last"}, 32'(lasts[i]), 32'(i == len - 1));
    end
    chk({tag, ":done_cnt"}, 32'(done_cnt), 32'(len != 0));
    chk({tag, ":done_time"}, 32'(done_bad), 32'h0);
    chk({tag, ":hold"}, 32'(hold_bad), 32'h0);
    chk({tag, ":trunc"}, 32'(truncated_o), 32'h0);
    if (vpct == 100 && rmode == 100 && len > 0 && acc_cyc.size() == len)
      chk({tag, ":b2b"}, 32'(acc_cyc[len-1] - acc_cyc[0]), 32'(len - 1));
    v_pct = 100;
    tick();
    chk({tag, ":rd_idle"}, 32'(adc_rd_en_o), 32'h0);
    chk({tag, ":tv_idle"}, 32'(m_axis_tvalid_o), 32'h0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4, 100, 100, -1, 1, 1'b1, "basic"};
    tbl[1] = '{8, 100, 200, -1, 0, 1'b1, "bp_toggle"};
    tbl[2] = '{0, 100, 100, -1, 0, 1'b0, "zero_len"};
    tbl[3] = '{5, 100, 100, 2, 0, 1'b1, "rearm"};
    tbl[4] = '{1, 100, 100, -1, 0, 1'b1, "len1"};
    tbl[5] = '{7, 40, 60, -1, 0, 1'b1, "sparse"};

    aresetn_i = 0;
    adc_valid_i = 0;
    adc_data_i = 0;
    arm_i = 0;
    abort_i = 0;
    frame_len_i = 0;
    trig_level_i = 16'h8001;
    m_axis_tready_i = 0;
    v_pct = 100;
    r_mode = 100;
    clear_bk();
    repeat (3) @(negedge clk_sys_i);
    chk("rst:tvalid", 32'(m_axis_tvalid_o), 32'h0);
    chk("rst:tdata", m_axis_tdata_o, 32'h0);
    chk("rst:tlast", 32'(m_axis_tlast_o), 32'h0);
    chk("rst:busy", 32'(busy_o), 32'h0);
    chk("rst:done", 32'(done_o), 32'h0);
    chk("rst:trunc", 32'(truncated_o), 32'h0);
    chk("rst:rd_en", 32'(adc_rd_en_o), 32'h0);
    aresetn_i = 1;
    @(negedge clk_sys_i);

    for (int t = 0; t < 6; t++)
      run_frame(tbl[t].len, tbl[t].vpct, tbl[t].rmode, tbl[t].rearm,
                tbl[t].src, tbl[t].exp_busy, tbl[t].name);

    // Abort with a pending beat after three accepted beats.
    clear_bk();
    src_q.delete();
    repeat (40) src_q.push_back($urandom);
    v_pct = 100;
    r_mode = 100;
    drive_inputs();
    frame_len_i = 16'd10;
    arm_i = 1;
    tick();
    for (int n = 0; n < 50 && beats.size() < 3; n++) tick();
    r_mode = 0;
    m_axis_tready_i = 0;
    abort_i = 1;
    tick();
    chk("abort:tvalid", 32'(m_axis_tvalid_o), 32'h1);
    chk("abort:tlast", 32'(m_axis_tlast_o), 32'h1);
    chk("abort:trunc", 32'(truncated_o), 32'h1);
    if (consumed.size() > 3)
      chk("abort:tdata", m_axis_tdata_o, consumed[3]);
    r_mode = 100;
    m_axis_tready_i = 1;
    tick();
    chk("abort:busy", 32'(busy_o), 32'h0);
    chk("abort:beats", 32'(beats.size()), 32'd4);
    chk("abort:consumed", 32'(consumed.size()), 32'd4);
    if (beats.size() == 4) chk("abort:last4", 32'(lasts[3]), 32'h1);
    chk("abort:no_done", 32'(done_cnt), 32'h0);
    chk("abort:trunc_stk", 32'(truncated_o), 32'h1);

    // Abort while armed: no frame, arm already cleared the sticky flag.
    clear_bk();
    v_pct = 0;
    drive_inputs();
    frame_len_i = 16'd5;
    arm_i = 1;
    tick();
    tick();
    chk("armabort:busy", 32'(busy_o), 32'h1);
    abort_i = 1;
    tick();
    chk("armabort:idle", 32'(busy_o), 32'h0);
    chk("armabort:trunc", 32'(truncated_o), 32'h0);
    chk("armabort:beats", 32'(beats.size()), 32'h0);

`ifdef ADC_FRAME_TRIG_EN
    src_q.delete();
    src_q.push_back(32'h0000_0000);
    src_q.push_back(32'h0000_0050);
    src_q.push_back(32'h0000_0120);
    src_q.push_back(32'h0000_0200);
    src_q.push_back(32'h0000_0300);
    trig_level_i = 16'h0100;
    run_frame(2, 100, 100, -1, 2, 1'b1, "trig");
    if (beats.size() == 2) begin
      chk("trig:w0", 32'(beats[0][15:0]), 32'h0120);
      chk("trig:w1", 32'(beats[1][15:0]), 32'h0200);
    end
    trig_level_i = 16'h8001;
`endif

    // Reset in the middle of a stalled frame.
    clear_bk();
    src_q.delete();
    repeat (40) src_q.push_back($urandom | 32'h1);
    v_pct = 100;
    r_mode = 0;
    m_axis_tready_i = 0;
    drive_inputs();
    frame_len_i = 16'd8;
    arm_i = 1;
    tick();
    repeat (3) tick();
    chk("mrst:pre_tv", 32'(m_axis_tvalid_o), 32'h1);
    chk("mrst:pre_busy", 32'(busy_o), 32'h1);
    #2;
    aresetn_i = 0;
    #1;
    chk("mrst:tvalid", 32'(m_axis_tvalid_o), 32'h0);
    chk("mrst:tdata", m_axis_tdata_o, 32'h0);
    chk("mrst:busy", 32'(busy_o), 32'h0);
    chk("mrst:rd_en", 32'(adc_rd_en_o), 32'h0);
    chk("mrst:tlast", 32'(m_axis_tlast_o), 32'h0);
    @(negedge clk_sys_i);
    aresetn_i = 1;
    run_frame(6, 100, 100, -1, 0, 1'b1, "post_rst");

    for (int r = 0; r < 20; r++) begin
      trig_level_i = 16'($urandom_range(0, 32767)) - 16'd16384;
      run_frame(int'($urandom_range(1, 12)),
                int'($urandom_range(30, 100)),
                int'($urandom_range(20, 100)),
                ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(0, 6)) : -1,
                0, 1'b1, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
